// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, frames
// 11-bit packets and folds E0/F0/E1 prefixes into single key events.
module ps2_kbd_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 32000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       rx_error
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_sh, data_sh;
  logic                  clk_filt, data_filt;
  logic                  fall;

  state_t                state, state_next;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift;
  logic                  par_bit;
  logic [TO_W-1:0]       to_cnt;
  logic [2:0]            skip_cnt;
  logic                  ext, rel;

  logic                  timeout, start_err, byte_ok, frame_err;
  logic                  is_ignore, is_prefix, emit;

  // Stage p0/p1: two-flop synchronizer, then FILTER_LEN-deep agreement filter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_sh    <= '1;
      data_sh   <= '1;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_sh    <= {clk_sh[FILTER_LEN-2:0], clk_sync[1]};
      data_sh   <= {data_sh[FILTER_LEN-2:0], data_sync[1]};
      if (&clk_sh)        clk_filt <= 1'b1;
      else if (~|clk_sh)  clk_filt <= 1'b0;
      if (&data_sh)       data_filt <= 1'b1;
      else if (~|data_sh) data_filt <= 1'b0;
    end
  end

  // Edge fires in the cycle the filter agrees on low, before the level register flips
  assign fall = clk_filt & ~|clk_sh;

  assign timeout   = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT)) && !fall;
  assign start_err = fall && (state == IDLE) && data_filt;
  assign byte_ok   = fall && (state == STOP) && data_filt && (^{shift, par_bit});
  assign frame_err = fall && (state == STOP) && !byte_ok;

  always_comb begin
    is_ignore = 1'b0;
    case (shift)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_ignore = 1'b1;
      default: is_ignore = 1'b0;
    endcase
  end

  assign is_prefix = (shift == 8'hE0) || (shift == 8'hF0) || (shift == 8'hE1);
  assign emit      = byte_ok && (skip_cnt == 3'd0) && !is_prefix && !is_ignore;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall && !data_filt)          state_next = DATA;
      DATA:    if (fall && (bit_cnt == 3'd7))   state_next = PARITY;
      PARITY:  if (fall)                        state_next = STOP;
      STOP:    if (fall)                        state_next = IDLE;
      default:                                  state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  // Stage p2: frame capture, prefix tracking and registered event outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      skip_cnt     <= '0;
      ext          <= 1'b0;
      rel          <= 1'b0;
      key_strobe   <= 1'b0;
      rx_error     <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= 8'h00;
    end else begin
      if (fall || (state == IDLE))       to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);

      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= 3'd0;
          DATA: begin
            shift   <= {data_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= data_filt;
          default: ;
        endcase
      end

      key_strobe <= emit;
      // Back-to-back error sources (timeout then a bad start) collapse into one pulse
      rx_error   <= (start_err || frame_err || timeout) && !rx_error;

      if (byte_ok) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
          ext      <= 1'b0;
          rel      <= 1'b0;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel <= 1'b1;
        end else if (shift == 8'hE1) begin
          skip_cnt <= 3'd7;
          ext      <= 1'b0;
          rel      <= 1'b0;
        end else begin
          ext <= 1'b0;
          rel <= 1'b0;
        end
      end

      if (emit) begin
        key_code     <= shift;
        key_extended <= ext;
        key_pressed  <= ~rel;
      end

      if (timeout) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end
    end
  end

endmodule
